// File: rtl/pipeline_exec_controller.sv
// pipeline_exec_controller: debug-path sequencer for the 5-stage MIPS pipeline.
// Loads program words into instruction memory, then runs the pipeline either
// continuously (with a fixed drain after the end instruction) or one cycle at
// a time, requesting a register/memory dump at each stop point.
// Optional feature: define CYCLE_WATCHDOG_EN to add MAX_CYCLES / o_timeout.
module pipeline_exec_controller #(
  parameter int unsigned IMEM_ADDR_W  = 8,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] END_WORD     = 32'hFFFFFFFF
`ifdef CYCLE_WATCHDOG_EN
  ,
  parameter logic [31:0] MAX_CYCLES   = 32'd65535
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_cmd_valid,
  input  logic [1:0]             i_cmd,
  output logic                   o_cmd_ready,
  input  logic                   i_load_valid,
  input  logic [31:0]            i_load_word,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_data,
  input  logic                   i_program_end,
  output logic                   o_halt,
  output logic                   o_pipe_reset,
  output logic                   o_dump_req,
  input  logic                   i_dump_done,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_load_err,
  output logic [31:0]            o_cycle_count
`ifdef CYCLE_WATCHDOG_EN
  ,
  output logic                   o_timeout
`endif
);

  localparam logic [1:0] CMD_LOAD  = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_STEP_EXEC,
    S_STEP_WAIT,
    S_DUMP,
    S_FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] ptr_q, ptr_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]            imem_data_q, imem_data_d;
  logic                   halt_q, halt_d;
  logic                   pipe_reset_q, pipe_reset_d;
  logic                   dump_req_q, dump_req_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   load_err_q, load_err_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            drain_q, drain_d;
  logic                   from_run_q, from_run_d;
  logic                   step_end_q, step_end_d;
  logic                   end_seen_q, end_seen_d;
  logic [31:0]            post_q, post_d;
`ifdef CYCLE_WATCHDOG_EN
  logic                   timeout_q, timeout_d;
`endif

  logic cmd_acc;

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    pipe_reset_d = pipe_reset_q;
    done_d       = done_q;
    load_err_d   = load_err_q;
    count_d      = count_q;
    drain_d      = drain_q;
    from_run_d   = from_run_q;
    step_end_d   = step_end_q;
    end_seen_d   = end_seen_q;
    post_d       = post_q;
`ifdef CYCLE_WATCHDOG_EN
    timeout_d    = timeout_q;
`endif

    cmd_acc = i_cmd_valid && cmd_ready_q;

    // Count every cycle the pipeline actually advanced, saturating.
    if (!halt_q && count_q != '1) begin
      count_d = count_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          if (i_cmd == CMD_LOAD) begin
            ptr_d        = '0;
            imem_addr_d  = '0;
            done_d       = 1'b0;
            load_err_d   = 1'b0;
            count_d      = '0;
            pipe_reset_d = 1'b1;
`ifdef CYCLE_WATCHDOG_EN
            timeout_d    = 1'b0;
`endif
            state_d      = S_LOAD;
          end else if ((i_cmd == CMD_RUN || i_cmd == CMD_STEP) && !load_err_q && !done_q) begin
            pipe_reset_d = 1'b0;
            end_seen_d   = 1'b0;
            post_d       = '0;
            state_d      = (i_cmd == CMD_RUN) ? S_RUN : S_STEP_EXEC;
          end
        end
      end

      S_LOAD: begin
        if (i_load_valid) begin
          imem_we_d   = 1'b1;
          imem_addr_d = ptr_q;
          imem_data_d = i_load_word;
          if (ptr_q != '1) begin
            ptr_d = ptr_q + 1'b1;
          end
          if (i_load_word == END_WORD) begin
            state_d = S_IDLE;
          end else if (ptr_q == '1) begin
            load_err_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (i_program_end) begin
          from_run_d = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_d = S_DUMP;
          end else begin
            drain_d = DRAIN_CYCLES - 1;
            state_d = S_DRAIN;
          end
        end
`ifdef CYCLE_WATCHDOG_EN
        if (count_d >= MAX_CYCLES) begin
          timeout_d  = 1'b1;
          from_run_d = 1'b1;
          state_d    = S_DUMP;
        end
`endif
      end

      // Counter is preloaded with DRAIN_CYCLES-1 so the DRAIN state itself
      // spans exactly DRAIN_CYCLES unhalted cycles.
      S_DRAIN: begin
        from_run_d = 1'b1;
        if (drain_q == '0) begin
          state_d = S_DUMP;
        end else begin
          drain_d = drain_q - 32'd1;
`ifdef CYCLE_WATCHDOG_EN
          if (count_d >= MAX_CYCLES) begin
            timeout_d = 1'b1;
            state_d   = S_DUMP;
          end
`endif
        end
      end

      // post_q counts steps taken after the one that first saw the end.
      S_STEP_EXEC: begin
        step_end_d = i_program_end;
        from_run_d = 1'b0;
        if (end_seen_q && post_q < DRAIN_CYCLES) begin
          post_d = post_q + 32'd1;
        end
        if (i_program_end) begin
          end_seen_d = 1'b1;
        end
        state_d = S_DUMP;
      end

      S_DUMP: begin
        if (i_dump_done) begin
          if (from_run_q || (step_end_q && post_q >= DRAIN_CYCLES)) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_STEP_WAIT;
          end
        end
      end

      S_STEP_WAIT: begin
        if (cmd_acc) begin
          if (i_cmd == CMD_STEP) begin
            state_d = S_STEP_EXEC;
          end else if (i_cmd == CMD_ABORT) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_FINISH) begin
      done_d       = 1'b1;
      pipe_reset_d = 1'b1;
    end

    halt_d      = !(state_d == S_RUN || state_d == S_DRAIN || state_d == S_STEP_EXEC);
    dump_req_d  = (state_d == S_DUMP);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE || state_d == S_STEP_WAIT);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= '0;
      halt_q       <= 1'b1;
      pipe_reset_q <= 1'b1;
      dump_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_err_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      count_q      <= '0;
      drain_q      <= '0;
      from_run_q   <= 1'b0;
      step_end_q   <= 1'b0;
      end_seen_q   <= 1'b0;
      post_q       <= '0;
`ifdef CYCLE_WATCHDOG_EN
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      halt_q       <= halt_d;
      pipe_reset_q <= pipe_reset_d;
      dump_req_q   <= dump_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_err_q   <= load_err_d;
      cmd_ready_q  <= cmd_ready_d;
      count_q      <= count_d;
      drain_q      <= drain_d;
      from_run_q   <= from_run_d;
      step_end_q   <= step_end_d;
      end_seen_q   <= end_seen_d;
      post_q       <= post_d;
`ifdef CYCLE_WATCHDOG_EN
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_imem_we     = imem_we_q;
  assign o_imem_addr   = imem_addr_q;
  assign o_imem_data   = imem_data_q;
  assign o_halt        = halt_q;
  assign o_pipe_reset  = pipe_reset_q;
  assign o_dump_req    = dump_req_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_load_err    = load_err_q;
  assign o_cycle_count = count_q;
`ifdef CYCLE_WATCHDOG_EN
  assign o_timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Testbench for pipeline_exec_controller: directed command sequences, a
// phase-level reference model compared every cycle, and literal expectations.
module tb_pipeline_exec_controller;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int DRAIN = 4;
`ifdef CYCLE_WATCHDOG_EN
  localparam int MAXC  = 20;
`endif

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic [1:0]    i_cmd = 2'b00;
  logic          o_cmd_ready;
  logic          i_load_valid = 1'b0;
  logic [31:0]   i_load_word = '0;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_data;
  logic          i_program_end = 1'b0;
  logic          o_halt, o_pipe_reset, o_dump_req;
  logic          i_dump_done = 1'b0;
  logic          o_busy, o_done, o_load_err;
  logic [31:0]   o_cycle_count;
`ifdef CYCLE_WATCHDOG_EN
  logic          o_timeout;
`endif

  pipeline_exec_controller #(
    .IMEM_ADDR_W (AW),
    .DRAIN_CYCLES(DRAIN)
`ifdef CYCLE_WATCHDOG_EN
    ,
    .MAX_CYCLES  (MAXC)
`endif
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .i_cmd        (i_cmd),
    .o_cmd_ready  (o_cmd_ready),
    .i_load_valid (i_load_valid),
    .i_load_word  (i_load_word),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_data  (o_imem_data),
    .i_program_end(i_program_end),
    .o_halt       (o_halt),
    .o_pipe_reset (o_pipe_reset),
    .o_dump_req   (o_dump_req),
    .i_dump_done  (i_dump_done),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_load_err   (o_load_err),
    .o_cycle_count(o_cycle_count)
`ifdef CYCLE_WATCHDOG_EN
    ,
    .o_timeout    (o_timeout)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  task automatic checkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks which phase the session is in by name and
  // derives the expected registered outputs after every clock edge.
  bit            m_on = 0;
  string         phase = "idle";
  int            drain_left, end_steps;
  bit            dump_from_run, last_step_end;
  logic [AW-1:0] ptr;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_cnt, e_data;
  bit            e_we, e_halt, e_pres, e_dump, e_busy, e_done, e_err, e_ready, e_to;

  always @(posedge clk) begin
    if (i_reset) begin
      phase = "idle"; ptr = '0; e_addr = '0; e_data = '0; e_cnt = '0; e_we = 0;
      e_done = 0; e_err = 0; e_pres = 1; e_to = 0; drain_left = -1; end_steps = 0;
      dump_from_run = 0; last_step_end = 0; m_on = 1;
    end else if (m_on) begin
      e_we = 0;
      if (!e_halt && e_cnt != 32'hFFFFFFFF) e_cnt = e_cnt + 32'd1;
      if (phase == "idle") begin
        if (i_cmd_valid) begin
          if (i_cmd == 2'b00) begin
            phase = "load"; ptr = '0; e_addr = '0; e_done = 0; e_err = 0; e_cnt = '0; e_to = 0;
          end else if (i_cmd != 2'b11 && !e_err && !e_done) begin
            e_pres = 0; end_steps = 0; drain_left = -1;
            phase = (i_cmd == 2'b01) ? "run" : "step";
          end
        end
      end else if (phase == "load") begin
        if (i_load_valid) begin
          e_we = 1; e_addr = ptr; e_data = i_load_word;
          if (i_load_word == 32'hFFFFFFFF) phase = "idle";
          else if (int'(ptr) == DEPTH - 1) begin e_err = 1; phase = "idle"; end
          else ptr = ptr + 1'b1;
        end
      end else if (phase == "run") begin
        if (drain_left < 0) begin
          if (i_program_end) drain_left = DRAIN;
        end else begin
          drain_left = drain_left - 1;
        end
        if (drain_left == 0) begin dump_from_run = 1; phase = "dump"; end
`ifdef CYCLE_WATCHDOG_EN
        else if (e_cnt >= MAXC) begin e_to = 1; dump_from_run = 1; phase = "dump"; end
`endif
      end else if (phase == "step") begin
        last_step_end = i_program_end;
        if (i_program_end) end_steps++;
        dump_from_run = 0;
        phase = "dump";
      end else if (phase == "dump") begin
        if (i_dump_done)
          phase = (dump_from_run || (last_step_end && end_steps > DRAIN)) ? "fin" : "wait";
      end else if (phase == "wait") begin
        if (i_cmd_valid && i_cmd == 2'b10) phase = "step";
        else if (i_cmd_valid && i_cmd == 2'b11) phase = "fin";
      end else begin
        phase = "idle";
      end
      if (phase == "fin") begin e_done = 1; e_pres = 1; end
    end
    e_halt  = !(phase == "run" || phase == "step");
    e_dump  = (phase == "dump");
    e_busy  = (phase != "idle");
    e_ready = (phase == "idle" || phase == "wait");
  end

  // Per-cycle comparison against the model, plus event logging for scenarios.
  int            halt_low_total = 0;
  int            dump_rise_total = 0;
  bit            prev_dump = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];

  always @(negedge clk) begin
    if (m_on) begin
      checkb("halt", o_halt, e_halt);
      checkb("pipe_reset", o_pipe_reset, e_pres);
      checkb("imem_we", o_imem_we, e_we);
      check("imem_addr", 32'(o_imem_addr), 32'(e_addr));
      check("imem_data", o_imem_data, e_data);
      checkb("dump_req", o_dump_req, e_dump);
      checkb("busy", o_busy, e_busy);
      checkb("done", o_done, e_done);
      checkb("load_err", o_load_err, e_err);
      checkb("cmd_ready", o_cmd_ready, e_ready);
      check("cycle_count", o_cycle_count, e_cnt);
`ifdef CYCLE_WATCHDOG_EN
      checkb("timeout", o_timeout, e_to);
`endif
      if (!o_halt) halt_low_total++;
      if (o_dump_req && !prev_dump) dump_rise_total++;
      prev_dump = o_dump_req;
      if (o_imem_we) begin wr_addr.push_back(o_imem_addr); wr_data.push_back(o_imem_data); end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cmd(input logic [1:0] c);
    i_cmd_valid = 1'b1; i_cmd = c; tick(); i_cmd_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    i_load_valid = 1'b1; i_load_word = w; tick(); i_load_valid = 1'b0;
  endtask

  task automatic do_dump();
    for (int k = 0; k < 60 && !o_dump_req; k++) tick();
    checkb("dump_req_seen", o_dump_req, 1'b1);
    checkb("ready_in_dump", o_cmd_ready, 1'b0);
    i_dump_done = 1'b1; tick(); i_dump_done = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  int hl0, dr0, w0;

  initial begin
    repeat (3) tick();
    i_reset = 1'b0;
    // Reset values pinned by hand.
    checkb("rst_halt", o_halt, 1'b1);
    checkb("rst_pipe_reset", o_pipe_reset, 1'b1);
    checkb("rst_ready", o_cmd_ready, 1'b1);
    check("rst_count", o_cycle_count, 32'd0);

    // ABORT in IDLE, stray load_valid and dump_done outside their states.
    cmd(2'b11); tick();
    load_word(32'h12345678); i_dump_done = 1'b1; tick(); i_dump_done = 1'b0;
    checkb("abort_idle_busy", o_busy, 1'b0);

    // Load a three-word program.
    w0 = wr_addr.size();
    cmd(2'b00);
    load_word(32'h20010005); load_word(32'h20020003); load_word(32'hFFFFFFFF);
    tick(); tick();
    check("load_nwr", wr_addr.size() - w0, 3);
    check("load_a0", 32'(wr_addr[w0]), 0);
    check("load_a2", 32'(wr_addr[w0+2]), 2);
    check("load_d0", wr_data[w0], 32'h20010005);
    check("load_d2", wr_data[w0+2], 32'hFFFFFFFF);
    checkb("load_err0", o_load_err, 1'b0);
    checkb("load_idle", o_busy, 1'b0);

    // Continuous run: end seen on RUN cycle index 10, then DRAIN cycles.
    hl0 = halt_low_total;
    cmd(2'b01);
    repeat (10) tick();
    i_program_end = 1'b1;
    do_dump();
    tick();
    i_program_end = 1'b0;
    check("run_count", o_cycle_count, 32'd15);
    check("run_halt_low", halt_low_total - hl0, 15);
    checkb("run_done", o_done, 1'b1);
    checkb("run_pipe_reset", o_pipe_reset, 1'b1);
    cmd(2'b01); tick();
    checkb("run_after_done_ignored", o_busy, 1'b0);

    // Overflow: four non-END words into a 4-deep memory.
    w0 = wr_addr.size();
    cmd(2'b00);
    for (int k = 0; k < 4; k++) load_word(32'h1000 + k);
    tick();
    check("ovf_nwr", wr_addr.size() - w0, 4);
    check("ovf_a3", 32'(wr_addr[w0+3]), 3);
    checkb("ovf_err", o_load_err, 1'b1);
    cmd(2'b01); tick(); tick();
    checkb("ovf_run_halt", o_halt, 1'b1);

    // Three single steps, then ABORT.
    cmd(2'b00); load_word(32'hFFFFFFFF); tick();
    hl0 = halt_low_total; dr0 = dump_rise_total;
    cmd(2'b10); do_dump();
    checkb("step_wait_ready", o_cmd_ready, 1'b1);
    cmd(2'b01); tick();
    checkb("step_wait_run_ignored", o_halt, 1'b1);
    cmd(2'b10); do_dump();
    cmd(2'b10); do_dump();
    check("step_count", o_cycle_count, 32'd3);
    check("step_halt_low", halt_low_total - hl0, 3);
    cmd(2'b11); tick(); tick();
    checkb("abort_done", o_done, 1'b1);
    checkb("abort_pipe_reset", o_pipe_reset, 1'b1);
    check("abort_dumps", dump_rise_total - dr0, 3);

    // Stepping past the end instruction until the drain rule finishes.
    cmd(2'b00); load_word(32'hFFFFFFFF); tick();
    cmd(2'b10); do_dump();
    i_program_end = 1'b1;
    for (int k = 0; k < 10 && !o_done; k++) begin
      cmd(2'b10); do_dump();
    end
    i_program_end = 1'b0;
    tick();
    checkb("stepend_done", o_done, 1'b1);
    check("stepend_count", o_cycle_count, 32'd6);

    // Reset during DRAIN.
    cmd(2'b00); load_word(32'hFFFFFFFF); tick();
    cmd(2'b01); tick(); tick();
    i_program_end = 1'b1; tick(); tick(); tick();
    i_reset = 1'b1; tick(); i_reset = 1'b0; i_program_end = 1'b0;
    checkb("mid_rst_halt", o_halt, 1'b1);
    checkb("mid_rst_pipe_reset", o_pipe_reset, 1'b1);
    checkb("mid_rst_dump", o_dump_req, 1'b0);
    checkb("mid_rst_busy", o_busy, 1'b0);
    checkb("mid_rst_ready", o_cmd_ready, 1'b1);
    check("mid_rst_count", o_cycle_count, 32'd0);
    check("mid_rst_addr", 32'(o_imem_addr), 32'd0);
    check("mid_rst_data", o_imem_data, 32'd0);

`ifdef CYCLE_WATCHDOG_EN
    // Watchdog: RUN with no end instruction.
    cmd(2'b00); load_word(32'hFFFFFFFF); tick();
    cmd(2'b01);
    do_dump();
    tick();
    checkb("wd_timeout", o_timeout, 1'b1);
    check("wd_count", o_cycle_count, 32'd20);
    checkb("wd_done", o_done, 1'b1);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_controller.md
Name: pipeline_exec_controller

Overview:
- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) for the debug path.
- Loads program words into instruction memory and runs the pipeline in continuous mode or single-step mode.
- In continuous mode, drains in-flight instructions after the end instruction is decoded, then requests a register/memory dump.
- Sits between the debug unit's command decoder and the pipeline's halt/reset inputs.

Parameters:
- IMEM_ADDR_W, 8, word address width of instruction memory (depth 2^IMEM_ADDR_W).
- DRAIN_CYCLES, 4, cycles the pipeline keeps running after i_program_end so ID/EX/MEM/WB retire.
- END_WORD, 32'hFFFFFFFF, program terminator word.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command strobe
- i_cmd  in  2  00 LOAD, 01 RUN, 10 STEP, 11 ABORT
- o_cmd_ready  out  1  controller accepts a command this cycle
- i_load_valid  in  1  load word strobe
- i_load_word  in  32  instruction word to store
- o_imem_we  out  1  instruction memory write enable
- o_imem_addr  out  IMEM_ADDR_W  instruction memory write address
- o_imem_data  out  32  instruction memory write data
- i_program_end  in  1  end instruction reached decode (level, sticky in ID)
- o_halt  out  1  freezes IF/ID and ID/EX and downstream latches
- o_pipe_reset  out  1  synchronous reset to pipeline stages (not register bank writes)
- o_dump_req  out  1  request dump of register bank / data memory
- i_dump_done  in  1  one-cycle pulse: dump finished
- o_busy  out  1  state != IDLE
- o_done  out  1  program finished and final dump sent; sticky until next LOAD
- o_load_err  out  1  program overflowed memory without END_WORD; sticky until next LOAD
- o_cycle_count  out  32  pipeline cycles executed (cycles with o_halt=0)

Behaviour:
- Reset values: state IDLE; o_halt=1, o_pipe_reset=1, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_dump_req=0, o_done=0, o_load_err=0, o_cycle_count=0, o_cmd_ready=1.
- Clock and reset: one clock i_clk; reset i_reset is synchronous and active-high. Reset mid-operation aborts any state; no partial-state retention.
- o_cmd_ready is 1 only in IDLE and STEP_WAIT. A command is accepted when i_cmd_valid & o_cmd_ready; commands at other times are ignored.
- States: IDLE, LOAD, RUN, DRAIN, STEP_EXEC, STEP_WAIT, DUMP, FINISH.
- IDLE + LOAD:
  - Clear o_imem_addr, o_done, o_load_err and o_cycle_count; hold o_pipe_reset=1, o_halt=1.
  - Go to LOAD.
- LOAD:
  - Each i_load_valid writes next cycle: o_imem_we=1 for exactly one cycle, o_imem_data=i_load_word, address = current pointer. The pointer increments after the write.
  - If the word == END_WORD, it is written, then go to IDLE with o_pipe_reset still 1.
  - If a write lands at address 2^IMEM_ADDR_W-1 and the word is not END_WORD, set o_load_err and go to IDLE. The pointer does not wrap.
- IDLE + RUN or STEP:
  - Ignored if o_load_err=1, or if o_done=1 (LOAD must come first).
  - Otherwise deassert o_pipe_reset for the rest of the session.
  - RUN goes to RUN; STEP goes to STEP_EXEC.
- RUN:
  - o_halt=0; o_cycle_count increments every cycle.
  - On i_program_end=1, load the drain counter with DRAIN_CYCLES and go to DRAIN.
- DRAIN:
  - o_halt=0; the counter decrements each cycle. When it reaches 0, o_halt=1 on the following cycle and go to DUMP.
  - Total post-end run cycles = DRAIN_CYCLES exactly.
- STEP_EXEC:
  - o_halt=0 for exactly one cycle; o_cycle_count += 1.
  - Then go to DUMP, recording a flag: step_end = i_program_end sampled in this cycle.
- DUMP:
  - o_halt=1; o_dump_req=1 held until i_dump_done.
  - On i_dump_done, drop o_dump_req the next cycle, then:
    - from DRAIN → FINISH;
    - from step with i_program_end=1 and at least DRAIN_CYCLES steps since end first seen → FINISH;
    - otherwise → STEP_WAIT.
- STEP_WAIT:
  - o_halt=1. STEP → STEP_EXEC.
  - ABORT → FINISH without a dump. RUN and LOAD are ignored.
- FINISH: set o_done=1, o_pipe_reset=1, o_halt=1; next cycle go to IDLE.
- ABORT accepted in IDLE: no effect.
- o_cycle_count saturates at 32'hFFFFFFFF.
- i_dump_done outside DUMP is ignored.
- i_load_valid outside LOAD is ignored.

Optional Feature:
- Macro CYCLE_WATCHDOG_EN.
- When defined: adds parameter MAX_CYCLES (default 65535) and output o_timeout (1 bit, reset 0, sticky until LOAD). In RUN or DRAIN, if o_cycle_count reaches MAX_CYCLES before the drain completes, set o_timeout and go to DUMP, then FINISH.
- When undefined: no port, no counter compare; RUN waits indefinitely for i_program_end.

Test Plan:
- LOAD then words 0x20010005, 0x20020003, 0xFFFFFFFF → three o_imem_we pulses at addrs 0,1,2; state IDLE; o_load_err=0.
- LOAD with IMEM_ADDR_W=2 and 4 non-END words → 4 writes at addrs 0..3; o_load_err=1; subsequent RUN ignored (o_halt stays 1).
- RUN, i_program_end rises at cycle 10 of RUN → exactly 4 more o_halt=0 cycles; o_dump_req rises; i_dump_done → o_done=1, o_cycle_count=15.
- STEP three times with dump handshakes → exactly 3 one-cycle o_halt=0 windows; o_cycle_count=3; o_cmd_ready=1 only in STEP_WAIT.
- STEP, dump, then ABORT → no further o_dump_req; o_done=1; o_pipe_reset=1.
- i_reset asserted during DRAIN → next cycle all outputs at reset values, state IDLE; (watchdog build: MAX_CYCLES=20, no i_program_end → o_timeout=1 at count 20, dump, o_done=1).
